ysyx_041461_mul_iter: RTL

- Parametrised, area-reduced successor to the fully parallel Booth/Wallace multiplier.
- Performs an XLEN x XLEN multiply with iterative radix-4 Booth recoding, one Booth group per cycle, producing a 2*XLEN result.
- Adds a valid/ready handshake on both sides, back-pressure on the output, a flush input and a reserved-mode check.
- Sits in the EXU next to the divider and serves MUL/MULH/MULHSU/MULHU.

---
 rtl/ysyx_041461_mul_pkg.sv | 42 ++++
 rtl/ysyx_041461_mul_booth_step.sv | 27 ++
 rtl/ysyx_041461_mul_iter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ysyx_041461_mul_pkg.sv
// Shared definitions for the iterative Booth multiplier: operand modes, FSM encoding, Booth digits.
package ysyx_041461_mul_pkg;

    localparam logic [1:0] MUL_UU  = 2'b00;
    localparam logic [1:0] MUL_SU  = 2'b01;
    localparam logic [1:0] MUL_SS  = 2'b10;
    localparam logic [1:0] MUL_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Bit 2 is the negate flag, bits [1:0] the magnitude (0, 1 or 2).
    typedef enum logic [2:0] {
        BD_ZERO = 3'b000,
        BD_POS1 = 3'b001,
        BD_POS2 = 3'b010,
        BD_NEG1 = 3'b101,
        BD_NEG2 = 3'b110
    } booth_digit_e;

    function automatic booth_digit_e booth_decode(input logic [2:0] grp);
        booth_digit_e d;
        case (grp)
            3'b001, 3'b010: d = BD_POS1;
            3'b011:         d = BD_POS2;
            3'b100:         d = BD_NEG2;
            3'b101, 3'b110: d = BD_NEG1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

    function automatic logic mode_a_signed(input logic [1:0] mode);
        return (mode == MUL_SU) || (mode == MUL_SS);
    endfunction

    function automatic logic mode_b_signed(input logic [1:0] mode);
        return mode == MUL_SS;
    endfunction

endpackage

// File: rtl/ysyx_041461_mul_booth_step.sv
// One radix-4 Booth step: maps a 3-bit multiplier group to digit * multiplicand, modulo 2^(2*XLEN).
module ysyx_041461_booth_step
    import ysyx_041461_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        grp,
    input  logic [2*XLEN-1:0] mcand,
    output logic [2*XLEN-1:0] addend
);

    localparam int PW = 2 * XLEN;

    logic [2:0]    digit;
    logic [PW-1:0] mag;

    always_comb begin
        digit = booth_decode(grp);
        case (digit[1:0])
            2'b01:   mag = mcand;
            2'b10:   mag = {mcand[PW-2:0], 1'b0};
            default: mag = '0;
        endcase
        addend = digit[2] ? (~mag + {{(PW-1){1'b0}}, 1'b1}) : mag;
    end

endmodule

// File: rtl/ysyx_041461_mul_iter.sv
// Iterative radix-4 Booth multiplier XLEN x XLEN -> 2*XLEN; STEPS+1 cycles accept-to-valid, result held until out_ready.
// Define YSYX_041461_MUL_EARLY_OUT_EN to finish once the remaining multiplier bits are all-zeros/all-ones (min 2 cycles).
module ysyx_041461_mul_iter
    import ysyx_041461_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [XLEN-1:0] in_multiplicand,
    input  logic [XLEN-1:0] in_multiplier,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_hi,
    output logic [XLEN-1:0] out_lo,
    output logic            busy
);

    localparam int STEPS = XLEN / 2 + 1;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int PW    = 2 * XLEN;
    localparam int MW    = XLEN + 3;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    logic [1:0]      state_q,  state_d;
    logic [PW-1:0]   mcand_q,  mcand_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q,    acc_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            fin_q,    fin_d;
    logic            rsv_q,    rsv_d;
    logic [XLEN-1:0] hi_q,     hi_d;
    logic [XLEN-1:0] lo_q,     lo_d;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   a_ext;
    logic [MW-1:0]   b_ext;
    logic [MW-1:0]   mplier_sh;
    logic            rest_trivial;

    ysyx_041461_booth_step #(
        .XLEN   (XLEN)
    ) u_booth_step (
        .grp    (mplier_q[2:0]),
        .mcand  (mcand_q),
        .addend (addend)
    );

    // The multiplier register carries the implicit zero below bit 0 as its LSB.
    assign a_ext = mode_a_signed(in_mode) ? {{XLEN{in_multiplicand[XLEN-1]}}, in_multiplicand}
                                          : {{XLEN{1'b0}}, in_multiplicand};
    assign b_ext = mode_b_signed(in_mode) ? {{2{in_multiplier[XLEN-1]}}, in_multiplier, 1'b0}
                                          : {2'b00, in_multiplier, 1'b0};

    assign mplier_sh = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};

`ifdef YSYX_041461_MUL_EARLY_OUT_EN
    assign rest_trivial = (mplier_sh == '0) || (mplier_sh == '1);
`else
    assign rest_trivial = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        rsv_d    = rsv_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d  = ST_CALC;
                        mcand_d  = a_ext;
                        mplier_d = b_ext;
                        acc_d    = '0;
                        cnt_d    = '0;
                        fin_d    = 1'b0;
                        rsv_d    = (in_mode == MUL_RSV);
                    end
                end
                ST_CALC: begin
                    // One settle edge after the final step moves the accumulator into the output registers.
                    if (fin_q) begin
                        state_d = ST_DONE;
                        hi_d    = rsv_q ? '0 : acc_q[PW-1:XLEN];
                        lo_d    = rsv_q ? '0 : acc_q[XLEN-1:0];
                    end else begin
                        acc_d    = acc_q + addend;
                        mcand_d  = {mcand_q[PW-3:0], 2'b00};
                        mplier_d = mplier_sh;
                        cnt_d    = cnt_q + CW'(1);
                        fin_d    = (cnt_q == LAST_STEP) || rest_trivial;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            rsv_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
            rsv_q    <= rsv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign out_hi    = hi_q;
    assign out_lo    = lo_q;

endmodule
